ttt_board_writer: RTL
=====================

TTT_BOARD_WRITER -- requirements
Module: ttt_board_writer

Interface
REQ-001 Parameter: FIRST_PLAYER, default 1'b0, player who moves first after reset/new_game (0 = P1 code 2'b01, 1 = P2 code 2'b10).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 new_game  input  1  synchronous board clear; same effect as rst; rst has priority.
REQ-005 move_valid  input  1  move request, sampled only while ready=1.
REQ-006 move_pos  input  4  target cell 0..8 (row-major: 0-2 top row, 6-8 bottom row).
REQ-007 ready  output  1  high when a move can be accepted.
REQ-008 move_ack  output  1  one-cycle pulse: legal move written and scanned.
REQ-009 move_err  output  1  one-cycle pulse: move rejected.
REQ-010 board  output  18  cell k at bits [2k+1:2k]; 00 empty, 01 P1, 10 P2; 11 never stored.
REQ-011 turn  output  1  player to move (0 = P1, 1 = P2).
REQ-012 game_over  output  1  level; high from end of game until rst/new_game.
REQ-013 winner  output  2  00 none, 01 P1, 10 P2; valid while game_over=1.
REQ-014 draw  output  1  level; high when board full with no winner.

Function
REQ-015 FSM states SHALL be IDLE, SCAN, OVER; ready=1 only in IDLE.
REQ-016 IDLE, move_valid=1 in cycle N: move is illegal if move_pos>8 or the target cell is non-empty.
REQ-017 Illegal move: board unchanged, move_err=1 in cycle N+1, state stays IDLE, turn unchanged.
REQ-018 Legal move: cell written with the turn player's code, visible on board in cycle N+1; state goes to SCAN.
REQ-019 SCAN SHALL check one line per cycle for 8 cycles (N+1..N+8), fixed order: rows 012,345,678; columns 036,147,258; diagonals 048,246.
REQ-020 A line wins when all three cells equal the mover's code; a sticky win flag accumulates across the scan; no early exit.
REQ-021 A move counter (0..9) SHALL increment on every legal move.
REQ-022 At end of SCAN (outputs visible in cycle N+9), exactly one outcome applies:
  - win: game_over=1, winner=mover code, state OVER, turn unchanged.
  - no win, counter=9: game_over=1, draw=1, winner=00, state OVER.
  - otherwise: turn toggles, state IDLE, ready=1.
  - In all three cases move_ack=1 for one cycle.
REQ-023 Accepted-move to ready latency SHALL be exactly 9 cycles.
REQ-024 move_valid during SCAN or OVER SHALL be ignored: no write, no move_err.
REQ-025 A win on the ninth move SHALL report winner, not draw.
REQ-026 new_game in any state, including mid-SCAN, SHALL discard the in-flight scan and apply reset values next cycle; a simultaneous move_valid is dropped.
REQ-027 move_ack and move_err SHALL never be high in the same cycle.

Reset
REQ-028 On rst or new_game: board=0, state IDLE, ready=1, turn=FIRST_PLAYER, counter=0, game_over=0, winner=00, draw=0, move_ack=0, move_err=0.
REQ-029 rst asserted with new_game: identical outcome; no partial state retained.

Verification
REQ-030 Legal move: pos=4 from reset -> board[9:8]=01 in N+1; move_ack in N+9; turn=1; ready=1 in N+9.
REQ-031 Rejections: pos=4 again -> move_err pulse in N+1, board unchanged; pos=9 -> move_err pulse; move_valid during SCAN -> no response.
REQ-032 P1 win, P1 plays 0,1,2 and P2 plays 3,4 -> after the fifth move: game_over=1, winner=01, draw=0; later move_valid ignored.
REQ-033 Draw sequence 0,1,2,4,3,5,7,6,8 -> draw=1, winner=00 after the ninth move; ninth-move win on diagonal 2,4,6 -> winner set, draw=0.
REQ-034 new_game pulsed at N+4 of a scan -> board=0, ready=1, turn=FIRST_PLAYER in the next cycle; no move_ack.
REQ-035 FIRST_PLAYER=1 -> first legal move writes 10; P2 win reports winner=10.

Source files
------------

// File: rtl/ttt_board_writer_if.sv
// Move request handshake between the player side (master) and the board writer (slave).
interface ttt_board_writer_if;
  logic       move_valid;
  logic [3:0] move_pos;
  logic       ready;
  logic       move_ack;
  logic       move_err;

  modport master (output move_valid, output move_pos,
                  input  ready, input move_ack, input move_err);
  modport slave  (input  move_valid, input move_pos,
                  output ready, output move_ack, output move_err);
endinterface

// File: rtl/ttt_board_writer.sv
// Tic-tac-toe board writer: validates and writes moves, then scans the eight
// lines one per cycle to decide win, draw or hand-over of the turn.
//
// state | meaning
// IDLE  | waiting for a move, ready=1
// SCAN  | checking one line per cycle after a legal write
// OVER  | game decided; moves ignored until rst/new_game
module ttt_board_writer #(
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  ttt_board_writer_if.slave  mv,
  output logic [17:0]        board,
  output logic               turn,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               draw
);
  typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

  state_t          state_q, state_d;
  logic [8:0][1:0] board_q, board_d;
  logic            turn_q, turn_d;
  logic [3:0]      move_cnt_q, move_cnt_d;
  logic [2:0]      scan_cnt_q, scan_cnt_d;
  logic            win_q, win_d;
  logic            ready_q, ready_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic            over_q, over_d;
  logic [1:0]      winner_q, winner_d;
  logic            draw_q, draw_d;

  logic [1:0] mover;
  logic [2:0] line_idx;
  logic [3:0] c0, c1, c2;
  logic       line_win;
  logic       pos_ok;
  logic       cell_free;

  assign mover     = turn_q ? 2'b10 : 2'b01;
  assign pos_ok    = (mv.move_pos <= 4'd8);
  assign cell_free = pos_ok && (board_q[mv.move_pos] == 2'b00);

  // Scan timer counts down 7..0; line order runs rows, columns, diagonals.
  assign line_idx = 3'd7 - scan_cnt_q;

  always_comb begin
    c0 = 4'd0;
    c1 = 4'd1;
    c2 = 4'd2;
    case (line_idx)
      3'd0: begin c0 = 4'd0; c1 = 4'd1; c2 = 4'd2; end
      3'd1: begin c0 = 4'd3; c1 = 4'd4; c2 = 4'd5; end
      3'd2: begin c0 = 4'd6; c1 = 4'd7; c2 = 4'd8; end
      3'd3: begin c0 = 4'd0; c1 = 4'd3; c2 = 4'd6; end
      3'd4: begin c0 = 4'd1; c1 = 4'd4; c2 = 4'd7; end
      3'd5: begin c0 = 4'd2; c1 = 4'd5; c2 = 4'd8; end
      3'd6: begin c0 = 4'd0; c1 = 4'd4; c2 = 4'd8; end
      default: begin c0 = 4'd2; c1 = 4'd4; c2 = 4'd6; end
    endcase
  end

  assign line_win = (board_q[c0] == mover) && (board_q[c1] == mover) &&
                    (board_q[c2] == mover);

  always_comb begin
    state_d    = state_q;
    board_d    = board_q;
    turn_d     = turn_q;
    move_cnt_d = move_cnt_q;
    scan_cnt_d = scan_cnt_q;
    win_d      = win_q;
    over_d     = over_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mv.move_valid) begin
          if (cell_free) begin
            board_d[mv.move_pos] = mover;
            move_cnt_d           = move_cnt_q + 4'd1;
            scan_cnt_d           = 3'd7;
            win_d                = 1'b0;
            state_d              = SCAN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      SCAN: begin
        win_d = win_q | line_win;
        if (scan_cnt_q == 3'd0) begin
          ack_d = 1'b1;
          // A win on the ninth move takes precedence over the full-board draw.
          if (win_d) begin
            over_d   = 1'b1;
            winner_d = mover;
            state_d  = OVER;
          end else if (move_cnt_q == 4'd9) begin
            over_d  = 1'b1;
            draw_d  = 1'b1;
            state_d = OVER;
          end else begin
            turn_d  = ~turn_q;
            state_d = IDLE;
          end
        end else begin
          scan_cnt_d = scan_cnt_q - 3'd1;
        end
      end
      OVER: begin
      end
      default: state_d = IDLE;
    endcase

    if (new_game) begin
      state_d    = IDLE;
      board_d    = '0;
      turn_d     = FIRST_PLAYER;
      move_cnt_d = 4'd0;
      scan_cnt_d = 3'd0;
      win_d      = 1'b0;
      over_d     = 1'b0;
      winner_d   = 2'b00;
      draw_d     = 1'b0;
      ack_d      = 1'b0;
      err_d      = 1'b0;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      board_q    <= '0;
      turn_q     <= FIRST_PLAYER;
      move_cnt_q <= 4'd0;
      scan_cnt_q <= 3'd0;
      win_q      <= 1'b0;
      ready_q    <= 1'b1;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      over_q     <= 1'b0;
      winner_q   <= 2'b00;
      draw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      board_q    <= board_d;
      turn_q     <= turn_d;
      move_cnt_q <= move_cnt_d;
      scan_cnt_q <= scan_cnt_d;
      win_q      <= win_d;
      ready_q    <= ready_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      over_q     <= over_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
    end
  end

  assign mv.ready    = ready_q;
  assign mv.move_ack = ack_q;
  assign mv.move_err = err_q;
  assign board       = board_q;
  assign turn        = turn_q;
  assign game_over   = over_q;
  assign winner      = winner_q;
  assign draw        = draw_q;
endmodule
